prio_encoder_rr: RTL and testbench
==================================

# prio_encoder_rr

Registered, parametrised N-input priority encoder/arbiter, the successor to the lab's combinational 8-to-3 priority encoder. Each cycle in which it is free, it samples an N-bit request vector and selects one winner. The winner is selected either by fixed priority (highest index wins) or by round-robin. The result is presented as a binary index plus one-hot grant, held stable under a valid/ready handshake until the downstream accepts it.

## Interface
- N, 8, number of request lines (>=2)
- IDX_W, 3, width of winner index; must equal ceil(log2(N))

- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  N  request vector; req[N-1] is the top fixed priority
- rr_mode  input  1  0 = fixed priority, 1 = round-robin; sampled only at capture
- out_valid  output  1  winner registered and presented
- out_ready  input  1  downstream accepts winner when out_valid & out_ready
- out_idx  output  IDX_W  binary index of winner
- out_onehot  output  N  one-hot grant, bit out_idx set
- busy  output  1  high in HOLD state (equals out_valid)

## Operation
- Two states: IDLE (out_valid=0) and HOLD (out_valid=1).
- Capture event:
  - IDLE with |req=1: winner is captured and the block enters HOLD.
  - HOLD with out_ready=1 and |req=1: next winner is captured and the block stays in HOLD (back-to-back).
- HOLD with out_ready=1 and req=0: block goes to IDLE and out_valid drops.
- HOLD with out_ready=0: out_idx and out_onehot are frozen; req changes are ignored.
- IDLE with req=0: block stays in IDLE; outputs keep their last values, which are don't-care while out_valid=0.
- Fixed priority (rr_mode=0): winner is the highest set index of req.
- Round-robin (rr_mode=1):
  - Search starts at index (last-1) mod N, descends with wrap, and the first set bit wins.
  - `last` is the index of the most recently captured winner.
  - After reset last=0, so the first round-robin search starts at N-1 and matches fixed priority.
- `last` updates on every capture, in both modes.
- Switching rr_mode never resets `last`.
- The captured winner stands even if its req bit deasserts before acceptance; requesters are not required to hold req.
- Single-hot req gives out_idx equal to that bit's index in both modes.

## Timing
- Reset (rst_n low, asynchronous, any state, including mid-HOLD):
  - out_valid=0, busy=0, out_idx=0, out_onehot=0, last=0, state=IDLE.
  - Reset release takes effect on the next rising edge.
- Latency: req sampled at edge k (IDLE) drives out_valid/out_idx/out_onehot after edge k.
- Handshake completes on a rising edge where out_valid & out_ready are both 1.
- Throughput: with req continuously non-zero and out_ready=1, one winner per cycle.
- out_ready while out_valid=0 has no effect.
- out_idx and out_onehot are registered and glitch-free; no combinational path from req to the outputs.

## Test plan
- Reset:
  - rst_n pulsed low mid-HOLD with out_idx=5 -> out_valid=0, out_idx=0, out_onehot=0 immediately, without waiting for a clock edge.
  - After release, req=0x01 -> out_idx=0 after one edge.
- Fixed-priority sweep:
  - rr_mode=0, out_ready=1, req=1<<i for i=7..0 (others random below i) -> out_idx=i, out_onehot=1<<i one cycle after each.
  - req=0 -> out_valid=0.
- Hold stability:
  - rr_mode=0, req=0x81 captured -> out_idx=7, out_onehot=0x80.
  - With out_ready=0 for 3 cycles while req changes to 0x01 -> outputs unchanged.
  - out_ready=1 -> next cycle out_idx=0.
- Round-robin rotation:
  - rr_mode=1, req=0xFF held, out_ready=1 -> out_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles.
  - req=0x24 -> alternates 5,2,5,2.
- Handshake drop/back-to-back:
  - Accept while req=0 -> out_valid=0 next cycle.
  - Accept while req=0x10 -> out_valid stays 1 with out_idx=4, no bubble.
- Mode switch:
  - After round-robin winner 5, switch rr_mode=0 with req=0xFF -> idx 7.
  - Switch back to rr_mode=1 -> search starts at 6 (last=7).

Source files
------------

// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder/arbiter with fixed-priority or round-robin
// winner selection, presented as index plus one-hot grant under valid/ready.
module prio_encoder_rr #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             rr_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [N-1:0]       onehot_q, onehot_d;

    logic [IDX_W-1:0]   fp_idx;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   win_idx;
    logic               capture;

    always_comb begin
        logic [IDX_W-1:0] pos;
        pos    = '0;
        fp_idx = '0;
        rr_idx = '0;
        // Ascending scan: the last set bit seen is the highest index.
        for (int i = 0; i < N; i++) begin
            pos = IDX_W'(i);
            if (req[pos]) begin
                fp_idx = pos;
            end
        end
        // Visit candidates from lowest to highest round-robin priority so the
        // final hit is (last-1) mod N or the nearest set bit below it, wrapping.
        for (int k = N; k >= 1; k--) begin
            pos = IDX_W'((int'(last_q) + N - k) % N);
            if (req[pos]) begin
                rr_idx = pos;
            end
        end
    end

    always_comb begin
        win_idx  = rr_mode ? rr_idx : fp_idx;
        capture  = ((state_q == IDLE) || out_ready) && (|req);
        state_d  = state_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        last_d   = last_q;
        if (capture) begin
            state_d  = HOLD;
            idx_d    = win_idx;
            onehot_d = N'(1) << win_idx;
            last_d   = win_idx;
        end else if ((state_q == HOLD) && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            onehot_q <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            last_q   <= last_d;
        end
    end

    assign out_valid  = (state_q == HOLD);
    assign busy       = (state_q == HOLD);
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr: expected winners are queued as stimulus is
// issued and a negedge monitor pops and compares them on each accepted handshake.
module tb_prio_encoder_rr;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             rr_mode;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [N-1:0]     out_onehot;
    logic             busy;

    int vectors;
    int miscompares;
    int exp_q[$];

    prio_encoder_rr #(.N(N), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .rr_mode    (rr_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Drive inputs just after a rising edge, optionally queue the winner, then
    // advance to just after the next rising edge.
    task automatic step(input logic [7:0] r, input logic rr, input logic rdy,
                        input bit push, input int exp_idx);
        req       = r;
        rr_mode   = rr;
        out_ready = rdy;
        if (push) exp_q.push_back(exp_idx);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake completes at the next rising edge whenever both are
    // high at the falling edge, since inputs only change just after rising edges.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_accept: got idx %0d, expected no output", out_idx);
            end else begin
                int e;
                logic [7:0] oh;
                e  = exp_q.pop_front();
                oh = 8'(1) << e;
                check("accept_idx", 32'(out_idx), 32'(e));
                check("accept_onehot", 32'(out_onehot), 32'(oh));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;
        int cyc;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req         = '0;
        rr_mode     = 1'b0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_idx", 32'(out_idx), 0);
        check("reset_onehot", 32'(out_onehot), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of HOLD with idx 5
        step(8'h20, 1'b0, 1'b0, 0, 0);
        step(8'h00, 1'b0, 1'b0, 0, 0);
        check("hold_idx5", 32'(out_idx), 5);
        check("hold_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_idx", 32'(out_idx), 0);
        check("async_rst_onehot", 32'(out_onehot), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'h01, 1'b0, 1'b1, 1, 0);
        step(8'h00, 1'b0, 1'b1, 0, 0);
        check("drop_after_rst", 32'(out_valid), 0);

        // Fixed-priority sweep with random lower bits
        for (int i = 7; i >= 0; i--) begin
            r = (8'(1) << i) | (8'($urandom) & ((8'(1) << i) - 8'(1)));
            step(r, 1'b0, 1'b1, 1, i);
        end
        step(8'h00, 1'b0, 1'b1, 0, 0);
        check("sweep_idle", 32'(out_valid), 0);

        // Hold stability while out_ready is low
        step(8'h81, 1'b0, 1'b1, 1, 7);
        for (int i = 0; i < 3; i++) begin
            step(8'h01, 1'b0, 1'b0, 0, 0);
            check("frozen_idx", 32'(out_idx), 7);
            check("frozen_onehot", 32'(out_onehot), 32'h80);
        end
        step(8'h01, 1'b0, 1'b1, 1, 0);
        step(8'h00, 1'b0, 1'b1, 0, 0);
        check("hold_idle", 32'(out_valid), 0);

        // Round-robin rotation from last=0
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 1'b1, 1'b1, 1, (i == 8) ? 7 : 7 - i);
        end
        step(8'h24, 1'b1, 1'b1, 1, 5);
        step(8'h24, 1'b1, 1'b1, 1, 2);
        step(8'h24, 1'b1, 1'b1, 1, 5);
        step(8'h24, 1'b1, 1'b1, 1, 2);
        step(8'h00, 1'b1, 1'b1, 0, 0);
        check("rr_idle", 32'(out_valid), 0);

        // Mode switch keeps last; back-to-back capture with no bubble
        step(8'h24, 1'b1, 1'b1, 1, 5);
        step(8'hFF, 1'b0, 1'b1, 1, 7);
        step(8'hFF, 1'b1, 1'b1, 1, 6);
        step(8'h10, 1'b1, 1'b1, 1, 4);
        check("b2b_valid", 32'(out_valid), 1);
        check("b2b_idx", 32'(out_idx), 4);
        step(8'h02, 1'b1, 1'b1, 1, 1);
        step(8'h40, 1'b0, 1'b1, 1, 6);
        step(8'h00, 1'b0, 1'b1, 0, 0);
        check("final_idle", 32'(out_valid), 0);

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            step(8'h00, 1'b0, 1'b1, 0, 0);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected winners never accepted, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
